// File: rtl/change_dispenser.sv
// Change dispenser: fires the soda motor, then pays out dimes/nickels
// through a two-tube hopper with drop-sensor confirmation and jam detection.
module change_dispenser #(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       soda_i,
  input  logic [2:0] change_i,
  input  logic       coin_sensed_i,
  input  logic       clear_i,
  output logic       busy_o,
  output logic       vend_o,
  output logic       dime_eject_o,
  output logic       nickle_eject_o,
  output logic       jam_o,
  output logic       err_o
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] VEND       = 3'd1;
  localparam logic [2:0] EJECT      = 3'd2;
  localparam logic [2:0] WAIT_SENSE = 3'd3;
  localparam logic [2:0] JAM        = 3'd4;

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] PLAST = PW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state, state_n;
  logic [2:0]    remaining, rem_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [TW-1:0] timer, timer_n;
  logic          dime_sel, dime_n;
  logic          err_n;
  logic          set_err, clr_err;
  logic [2:0]    left;

  assign left = remaining - (dime_sel ? 3'd2 : 3'd1);

  always_comb begin
    state_n = state;
    rem_n   = remaining;
    pcnt_n  = pcnt;
    timer_n = timer;
    dime_n  = dime_sel;
    err_n   = err_o;
    set_err = soda_i && ((state != IDLE) || (change_i > 3'd4));
    clr_err = clear_i && ((state == IDLE) || (state == JAM));
    unique case (state)
      IDLE: begin
        if (soda_i && (change_i <= 3'd4)) begin
          state_n = VEND;
          rem_n   = change_i;
        end
      end
      VEND: begin
        if (remaining == 3'd0) begin
          state_n = IDLE;
        end else begin
          state_n = EJECT;
          pcnt_n  = '0;
          dime_n  = (remaining >= 3'd2);
        end
      end
      EJECT: begin
        if (pcnt == PLAST) begin
          state_n = WAIT_SENSE;
          timer_n = '0;
        end else begin
          pcnt_n = pcnt + 1'b1;
        end
      end
      WAIT_SENSE: begin
        // a sense on the last timeout cycle still counts as delivered
        if (coin_sensed_i) begin
          rem_n   = left;
          pcnt_n  = '0;
          dime_n  = (left >= 3'd2);
          state_n = (left == 3'd0) ? IDLE : EJECT;
        end else if (timer == TLAST) begin
          state_n = JAM;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      JAM: begin
        if (clear_i) begin
          state_n = IDLE;
          rem_n   = 3'd0;
        end
      end
      default: state_n = IDLE;
    endcase
    if (set_err) begin
      err_n = 1'b1;
    end else if (clr_err) begin
      err_n = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      remaining      <= 3'd0;
      pcnt           <= '0;
      timer          <= '0;
      dime_sel       <= 1'b0;
      busy_o         <= 1'b0;
      vend_o         <= 1'b0;
      dime_eject_o   <= 1'b0;
      nickle_eject_o <= 1'b0;
      jam_o          <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      state          <= state_n;
      remaining      <= rem_n;
      pcnt           <= pcnt_n;
      timer          <= timer_n;
      dime_sel       <= dime_n;
      busy_o         <= (state_n != IDLE);
      vend_o         <= (state_n == VEND);
      dime_eject_o   <= (state_n == EJECT) && dime_n;
      nickle_eject_o <= (state_n == EJECT) && !dime_n;
      jam_o          <= (state_n == JAM);
      err_o          <= err_n;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: fixed vector table, corner-case sequences
// and randomized traffic against a coin-queue reference model.
module tb_change_dispenser;

  localparam int P  = 4;
  localparam int TO = 40;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       soda_i = 1'b0;
  logic [2:0] change_i = 3'd0;
  logic       coin_sensed_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       busy_o, vend_o, dime_eject_o, nickle_eject_o, jam_o, err_o;

  change_dispenser #(.PULSE_CYCLES(P), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .soda_i(soda_i), .change_i(change_i),
    .coin_sensed_i(coin_sensed_i), .clear_i(clear_i), .busy_o(busy_o),
    .vend_o(vend_o), .dime_eject_o(dime_eject_o),
    .nickle_eject_o(nickle_eject_o), .jam_o(jam_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  // reference model: payout as a queue of coin values
  typedef enum {M_IDLE, M_VEND, M_PULSE, M_WAIT, M_JAM} phase_t;
  phase_t ph = M_IDLE;
  int     coins[$];
  int     pulse_left = 0;
  int     waited = 0;
  bit     m_err = 0;

  function automatic void model_reset();
    ph = M_IDLE;
    coins.delete();
    pulse_left = 0;
    waited = 0;
    m_err = 0;
  endfunction

  function automatic void model_step(bit s, bit [2:0] c, bit sn, bit cl);
    bit set_e, clr_e;
    int cents;
    set_e = s && (ph != M_IDLE || c > 4);
    clr_e = cl && (ph == M_IDLE || ph == M_JAM);
    case (ph)
      M_IDLE: if (s && c <= 4) begin
        coins.delete();
        cents = 5 * int'(c);
        while (cents >= 10) begin coins.push_back(2); cents -= 10; end
        if (cents == 5) coins.push_back(1);
        ph = M_VEND;
      end
      M_VEND: if (coins.size() == 0) ph = M_IDLE;
              else begin ph = M_PULSE; pulse_left = P; end
      M_PULSE: begin
        pulse_left--;
        if (pulse_left == 0) begin ph = M_WAIT; waited = 0; end
      end
      M_WAIT: if (sn) begin
        void'(coins.pop_front());
        if (coins.size() == 0) ph = M_IDLE;
        else begin ph = M_PULSE; pulse_left = P; end
      end else begin
        waited++;
        if (waited == TO) ph = M_JAM;
      end
      M_JAM: if (cl) begin ph = M_IDLE; coins.delete(); end
      default: ph = M_IDLE;
    endcase
    if (set_e) m_err = 1;
    else if (clr_e) m_err = 0;
  endfunction

  function automatic logic [5:0] model_outs();
    bit pulsing;
    pulsing = (ph == M_PULSE) && coins.size() > 0;
    return {ph != M_IDLE, ph == M_VEND, pulsing && coins[0] == 2,
            pulsing && coins[0] == 1, ph == M_JAM, m_err};
  endfunction

  function automatic logic [5:0] outs();
    return {busy_o, vend_o, dime_eject_o, nickle_eject_o, jam_o, err_o};
  endfunction

  function automatic void check(string name, logic [5:0] got, logic [5:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (busy,vend,dime,nick,jam,err) at %0t",
               name, got, want, $time);
    end
  endfunction

  function automatic void chk(string name, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endfunction

  task automatic step(input bit s, input bit [2:0] c, input bit sn, input bit cl);
    @(negedge clk_i);
    soda_i = s; change_i = c; coin_sensed_i = sn; clear_i = cl;
    @(posedge clk_i);
    model_step(s, c, sn, cl);
    #1;
    check("model", outs(), model_outs());
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    soda_i = 0; change_i = 0; coin_sensed_i = 0; clear_i = 0;
    #1;
    check("reset_async", outs(), 6'b0);
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic payout(input int ch, input int dly, input bit overlap,
                        output int dc, output int nc, output int dp,
                        output int vn, output bit done);
    int wc;
    bit pd, sn, sd, in_wait;
    dc = 0; nc = 0; dp = 0; vn = 0; done = 0; wc = 0; pd = 0;
    step(1'b1, 3'(ch), 1'b0, 1'b0);
    for (int i = 0; i < 400 && !done; i++) begin
      if (vend_o) vn++;
      if (dime_eject_o) begin dc++; if (!pd) dp++; end
      if (nickle_eject_o) nc++;
      pd = dime_eject_o;
      if (!busy_o) done = 1;
      else begin
        in_wait = busy_o && !vend_o && !dime_eject_o && !nickle_eject_o && !jam_o;
        wc = in_wait ? wc + 1 : 0;
        sn = in_wait && wc == dly;
        sd = overlap && dime_eject_o && dc == 2;
        step(sd, 3'd0, sn, 1'b0);
      end
    end
  endtask

  typedef struct {
    bit       soda;
    bit [2:0] ch;
    bit       sense;
    bit       clr;
    bit [5:0] exp;
  } vec_t;

  vec_t tbl[23];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  initial begin
    int dc, nc, dp, vn, went, jidx;
    bit done;

    tbl[0]  = '{1, 3'd0, 0, 0, 6'b110000};
    tbl[1]  = '{0, 3'd0, 0, 0, 6'b000000};
    tbl[2]  = '{1, 3'd6, 0, 0, 6'b000001};
    tbl[3]  = '{0, 3'd0, 0, 0, 6'b000001};
    tbl[4]  = '{0, 3'd0, 0, 1, 6'b000000};
    tbl[5]  = '{1, 3'd1, 0, 0, 6'b110000};
    tbl[6]  = '{0, 3'd0, 0, 0, 6'b100100};
    tbl[7]  = '{0, 3'd0, 0, 0, 6'b100100};
    tbl[8]  = '{0, 3'd0, 0, 0, 6'b100100};
    tbl[9]  = '{0, 3'd0, 0, 0, 6'b100100};
    tbl[10] = '{0, 3'd0, 0, 0, 6'b100000};
    tbl[11] = '{0, 3'd0, 1, 0, 6'b000000};
    tbl[12] = '{0, 3'd0, 1, 0, 6'b000000};
    tbl[13] = '{1, 3'd2, 0, 0, 6'b110000};
    tbl[14] = '{0, 3'd0, 0, 0, 6'b101000};
    tbl[15] = '{1, 3'd0, 0, 0, 6'b101001};
    tbl[16] = '{0, 3'd0, 0, 0, 6'b101001};
    tbl[17] = '{0, 3'd0, 0, 0, 6'b101001};
    tbl[18] = '{0, 3'd0, 0, 0, 6'b100001};
    tbl[19] = '{0, 3'd0, 1, 0, 6'b000001};
    tbl[20] = '{0, 3'd0, 0, 1, 6'b000000};
    tbl[21] = '{1, 3'd7, 0, 1, 6'b000001};
    tbl[22] = '{0, 3'd0, 0, 1, 6'b000000};

    do_reset();
    check("reset_state", outs(), 6'b0);

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].soda, tbl[i].ch, tbl[i].sense, tbl[i].clr);
      check($sformatf("table[%0d]", i), outs(), tbl[i].exp);
    end

    payout(4, 3, 0, dc, nc, dp, vn, done);
    chk("full_done", int'(done), 1);
    chk("full_dime_cycles", dc, 2 * P);
    chk("full_dime_pulses", dp, 2);
    chk("full_nickel_cycles", nc, 0);
    chk("full_vends", vn, 1);

    payout(3, 2, 0, dc, nc, dp, vn, done);
    chk("mixed_done", int'(done), 1);
    chk("mixed_dime_cycles", dc, P);
    chk("mixed_nickel_cycles", nc, P);

    payout(2, 3, 1, dc, nc, dp, vn, done);
    chk("overlap_done", int'(done), 1);
    chk("overlap_vends", vn, 1);
    chk("overlap_dime_pulses", dp, 1);
    chk("overlap_err", int'(err_o), 1);
    step(0, 3'd0, 0, 1);

    step(1, 3'd1, 0, 0);
    went = -1; jidx = -1;
    for (int i = 0; i < 200 && jidx < 0; i++) begin
      if (went < 0 && busy_o && !vend_o && !nickle_eject_o && !jam_o) went = i;
      if (jam_o) jidx = i;
      else step(0, 3'd0, 0, 0);
    end
    chk("jam_latency", jidx - went, TO);
    chk("jam_busy", int'(busy_o), 1);
    step(0, 3'd0, 1, 0);
    chk("jam_sticky", int'(jam_o), 1);
    step(0, 3'd0, 0, 1);
    chk("jam_clear_busy", int'(busy_o), 0);

    payout(1, TO, 0, dc, nc, dp, vn, done);
    chk("late_sense_no_jam", int'(done), 1);
    chk("late_sense_nickel", nc, P);

    step(1, 3'd2, 0, 0);
    step(0, 3'd0, 0, 0);
    step(0, 3'd0, 0, 0);
    check("mid_pulse_before_rst", outs(), 6'b101000);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check("reset_mid_pulse", outs(), 6'b0);
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    step(1, 3'd0, 0, 0);
    check("after_reset_req", outs(), 6'b110000);
    step(0, 3'd0, 0, 0);
    check("after_reset_idle", outs(), 6'b000000);

    do_reset();
    for (int seg = 0; seg < 15; seg++) begin
      int srate;
      srate = (seg % 4 == 3) ? 0 : 5;
      for (int i = 0; i < 200; i++) begin
        bit s, sn, cl;
        s  = ($urandom_range(0, 9) == 0);
        sn = (srate != 0) && ($urandom_range(0, srate - 1) == 0);
        cl = ($urandom_range(0, 39) == 0);
        step(s, 3'($urandom_range(0, 7)), sn, cl);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Back-end consumer of the vending controller's `soda`/`change` outputs. On each vend request it fires the soda-drop motor once, then pays out the change through a two-tube coin hopper (dimes, nickels), dimes first. Each coin is confirmed by the hopper's drop sensor. A supervision timer flags a jammed tube. The block sits between the vending FSM and the physical actuators.

## Interface
Parameters:
- `PULSE_CYCLES`, 4: width in cycles of each eject pulse (≥1).
- `TIMEOUT_CYCLES`, 1000: cycles to wait for drop-sensor confirmation before declaring jam (≥2).

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `soda_i`  in  1  one-cycle vend request from vending FSM.
- `change_i`  in  3  change owed in nickels, sampled with `soda_i`. Valid 0..4 (0–20¢); 5..7 invalid.
- `coin_sensed_i`  in  1  hopper drop sensor, one-cycle pulse per coin.
- `clear_i`  in  1  operator clear; exits JAM and clears `err_o`.
- `busy_o`  out  1  request in progress.
- `vend_o`  out  1  one-cycle soda-motor pulse.
- `dime_eject_o`  out  1  dime solenoid drive.
- `nickle_eject_o`  out  1  nickel solenoid drive.
- `jam_o`  out  1  high while in JAM.
- `err_o`  out  1  sticky protocol-error flag.

## Operation
- States: IDLE, VEND, EJECT, WAIT_SENSE, JAM.
- Reset (async, any state): state=IDLE; remaining=0; timer=0; all outputs 0.
- **IDLE**
  - `soda_i`=1 and `change_i`≤4: latch remaining=`change_i` and go to VEND.
  - `soda_i`=1 and `change_i`≥5: stay IDLE, no vend, set `err_o`.
- **VEND**: `vend_o`=1 for exactly this cycle.
  - Next state is IDLE if remaining=0, else EJECT.
- **EJECT**: lasts exactly `PULSE_CYCLES` cycles.
  - remaining≥2: `dime_eject_o`=1 for the whole pulse.
  - remaining=1: `nickle_eject_o`=1 for the whole pulse.
  - Coin type is fixed at EJECT entry. Both eject outputs are never high together.
  - After the pulse, go to WAIT_SENSE with timer=0.
- **WAIT_SENSE**: timer increments each cycle.
  - `coin_sensed_i`=1: subtract the coin (2 for a dime, 1 for a nickel) from remaining. Go to IDLE if the result is 0, else EJECT.
  - timer reaches `TIMEOUT_CYCLES`-1 without a sense: go to JAM.
  - Sense and timeout in the same cycle: the sense wins.
- **JAM**: `jam_o`=1; remaining is held for diagnostics.
  - `clear_i`=1: go to IDLE, discard remaining, clear `err_o`.
  - No other exit except reset.
- `busy_o` is 1 in every state other than IDLE, including JAM.
- `coin_sensed_i` outside WAIT_SENSE is ignored, with no error.
- `soda_i`=1 while not in IDLE: the request is dropped, `err_o` is set, and the current payout is unaffected.
- `clear_i` in IDLE clears `err_o`. In VEND, EJECT or WAIT_SENSE it has no effect.
- If `err_o` is set and cleared in the same cycle, the set wins.
- remaining is 3 bits and never underflows: a dime is only chosen when remaining≥2.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Request sampled in cycle T (IDLE): `busy_o`=1 and `vend_o`=1 in T+1.
- First eject asserted T+2 through T+1+`PULSE_CYCLES`.
- WAIT_SENSE entered at T+2+`PULSE_CYCLES`.
- Sense sampled in cycle S: next EJECT (or IDLE with `busy_o`=0) in S+1.
- Timeout: with no sense, JAM (`jam_o`=1) is entered `TIMEOUT_CYCLES` cycles after WAIT_SENSE entry.
- Zero change: `busy_o` high for 1 cycle (T+1); a new request is accepted at T+2.
- `err_o` rises the cycle after the offending sample.
- Throughput: one coin per `PULSE_CYCLES` + sensor latency + 1 cycles.

## Test plan
- **Zero change**: reset, `soda_i`=1 with `change_i`=0 → `vend_o` pulse at T+1, no ejects, `busy_o` low at T+2.
- **Full change**: `change_i`=4 with sensor replying 3 cycles after each pulse → exactly 2 dime pulses of 4 cycles each, zero nickel pulses, then IDLE.
- **Mixed and invalid codes**:
  - `change_i`=3 → one dime, then one nickel.
  - `change_i`=6 → no vend, `err_o`=1; `clear_i` → `err_o`=0.
- **Jam**: `change_i`=1 and sensor never fires → `jam_o`=1 exactly `TIMEOUT_CYCLES` cycles after WAIT_SENSE entry, `busy_o` stays 1. `clear_i` → IDLE.
  - Repeat with the sense arriving on the final timeout cycle → no jam.
- **Overlapping request**: `soda_i` during an EJECT of a `change_i`=2 payout → `err_o`=1, only one `vend_o`, one dime delivered.
- **Reset mid-payout**: assert `rst_i` mid-pulse → all outputs 0 immediately, without waiting for a clock edge. After release the block is in IDLE and accepts a new request.
